proc_net_interface: RTL and testbench
=====================================

# proc_net_interface

Parametrised processor-to-network interface between the pipelined MIPS core and its NoC router port. It replaces the unbuffered, unflow-controlled send/receive hooks with buffered TX and RX paths, valid/ready handshakes on both sides, flit packing with source and destination fields, local loopback, and misroute detection. The interface sits beside the core's execute/decode stages: the core pushes send words, the router drains flits, and the core pops received words into its register-file write port.

## Interface
- DATA_W, 32, payload width
- NUM_NODES, 4, nodes on the network; ADDR_W = max(1, clog2(NUM_NODES)) is derived
- TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2)
- FLIT_W, derived, = DATA_W + 2*ADDR_W; flit is {dest, src, payload}, dest in the MSBs

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- current_node  in  ADDR_W  this node's address, held static
- proc_valid  in  1  core offers a send word
- proc_ready  out  1  TX FIFO can accept
- proc_dest  in  ADDR_W  destination node of the send word
- proc_data  in  DATA_W  send payload
- net_tx_valid  out  1  flit offered to router
- net_tx_ready  in  1  router accepts flit
- net_tx_flit  out  FLIT_W  outgoing flit
- net_rx_valid  in  1  router offers flit
- net_rx_ready  out  1  RX path can accept
- net_rx_flit  in  FLIT_W  incoming flit
- rx_valid  out  1  received word available
- rx_data  out  DATA_W  received payload (RX FIFO head)
- rx_src  out  ADDR_W  source node of rx_data
- rx_pop  in  1  core consumes head word
- misroute  out  1  one-cycle pulse: accepted flit had dest ≠ current_node
- misroute_cnt  out  8  saturating count of misroutes
- tx_count  out  clog2(TX_DEPTH+1)  TX occupancy
- rx_count  out  clog2(RX_DEPTH+1)  RX occupancy

## Operation
- TX push: proc_valid && proc_ready writes {proc_dest, current_node, proc_data}. proc_ready = !tx_full && !rst.
- TX head dispatch:
  - If head dest ≠ current_node: net_tx_valid = 1 and net_tx_flit = head. Pop on net_tx_valid && net_tx_ready.
  - If head dest = current_node (loopback): net_tx_valid = 0. The head moves into the RX FIFO when the RX FIFO is not full and no network RX write occurs in the same cycle.
- RX accept: net_rx_ready = !rx_full && !rst. On net_rx_valid && net_rx_ready:
  - If dest = current_node: write {src, payload} to the RX FIFO.
  - Otherwise: drop the flit, pulse misroute the next cycle, and increment misroute_cnt, saturating at 255.
- Arbitration on the RX FIFO write port: network beats loopback. Loopback retries the following cycle and is never dropped.
- RX pop: rx_valid = !rx_empty. rx_pop && rx_valid pops. rx_pop with rx_valid = 0 is ignored.
- FIFOs support a simultaneous push and pop in one cycle; occupancy is then unchanged. A push is never accepted while full, because ready is low.
- Ordering: words from one source to one destination are delivered in push order, loopback included.
- Reset (async, also mid-transfer): both FIFOs are flushed and misroute_cnt is cleared. While rst is high, every output is 0. In-flight words are lost.

## Timing
- All outputs are 0 during reset. On the first cycle after release, proc_ready = 1, net_rx_ready = 1, and all other outputs are 0.
- TX latency: a word pushed at edge N is visible on net_tx_flit / net_tx_valid after edge N (first-word fall-through, 1 cycle).
- Loopback latency: push at edge N, head transfers at edge N+1, rx_valid goes high after edge N+1 (2 cycles, absent contention).
- RX latency: flit accepted at edge N gives rx_valid high after edge N.
- Holding rules: net_tx_valid/net_tx_flit stay stable until accepted. The core must hold proc_* stable while proc_valid && !proc_ready.
- Ready outputs depend only on registered occupancy and rst; there is no combinational path from any valid input.
- Counters update on the same edge as the push/pop that changes them.

## Structure
- Shared package noc_pkg: ADDR_W derivation, flit field offsets, and flit pack/unpack functions. The router reuses these.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): first-word fall-through, async active-high reset, with full/empty/count outputs. It is instantiated twice: TX with WIDTH = FLIT_W, RX with WIDTH = ADDR_W + DATA_W.
- Top level holds the dispatch/loopback arbitration, misroute detection and counter.

## Test plan
- Remote send (current_node = 1): push dest 2, data 0xDEADBEEF with net_tx_ready = 1 → next cycle net_tx_valid = 1, net_tx_flit = {2'd2, 2'd1, 32'hDEADBEEF}; popped that edge.
- Backpressure: hold net_tx_ready = 0 and push 5 words → proc_ready drops after 4 (tx_count = 4). Release → 4 flits leave in order, one per cycle, and proc_ready returns.
- Loopback: push dest 1, data 0x12345678 on node 1 → net_tx_valid stays 0; two cycles later rx_valid = 1, rx_data = 0x12345678, rx_src = 1.
- Contention: loopback head pending while a network flit for node 1 arrives the same cycle → network word written first, loopback word next cycle; RX order is network then loopback.
- Misroute: inject flit dest 3 on node 1 → flit accepted, misroute pulses once, misroute_cnt = 1, rx_valid stays 0. Inject 300 misroutes → misroute_cnt = 255.
- Reset mid-operation: TX and RX holding 3 words each, pulse rst asynchronously between edges → all outputs 0 immediately; after release, tx_count = 0, rx_count = 0, proc_ready = 1.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared network-on-chip definitions used by the processor
// interface and the router: address width derivation, flit field offsets
// and pack/unpack helpers for the default network configuration.
package noc_pkg;

    // Address bits needed to name one of num_nodes nodes (at least one bit).
    function automatic int calc_addr_w(input int num_nodes);
        return (num_nodes > 2) ? $clog2(num_nodes) : 1;
    endfunction

    // A flit carries {dest, src, payload}, dest in the MSBs.
    function automatic int calc_flit_w(input int data_w, input int addr_w);
        return data_w + 2 * addr_w;
    endfunction

    function automatic int src_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dest_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_NODES = 4;
    localparam int DEF_ADDR_W    = calc_addr_w(DEF_NUM_NODES);
    localparam int DEF_FLIT_W    = calc_flit_w(DEF_DATA_W, DEF_ADDR_W);

    typedef logic [DEF_ADDR_W-1:0] node_addr_t;
    typedef logic [DEF_DATA_W-1:0] payload_t;

    typedef struct packed {
        node_addr_t dest;
        node_addr_t src;
        payload_t   payload;
    } flit_t;

    function automatic flit_t pack_flit(input node_addr_t dest,
                                        input node_addr_t src,
                                        input payload_t   payload);
        flit_t f;
        f.dest    = dest;
        f.src     = src;
        f.payload = payload;
        return f;
    endfunction

    function automatic flit_t unpack_flit(input logic [DEF_FLIT_W-1:0] raw);
        return flit_t'(raw);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO. The head entry is always visible
// on rd_data; push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/proc_net_interface.sv
// proc_net_interface: buffered core-to-router port with flit packing,
// local loopback, network-over-loopback arbitration and misroute counting.
module proc_net_interface
    import noc_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int NUM_NODES = 4,
    parameter  int TX_DEPTH  = 4,
    parameter  int RX_DEPTH  = 4,
    localparam int ADDR_W    = calc_addr_w(NUM_NODES),
    localparam int FLIT_W    = calc_flit_w(DATA_W, ADDR_W)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_W-1:0]                 current_node,
    input  logic                              proc_valid,
    output logic                              proc_ready,
    input  logic [ADDR_W-1:0]                 proc_dest,
    input  logic [DATA_W-1:0]                 proc_data,
    output logic                              net_tx_valid,
    input  logic                              net_tx_ready,
    output logic [FLIT_W-1:0]                 net_tx_flit,
    input  logic                              net_rx_valid,
    output logic                              net_rx_ready,
    input  logic [FLIT_W-1:0]                 net_rx_flit,
    output logic                              rx_valid,
    output logic [DATA_W-1:0]                 rx_data,
    output logic [ADDR_W-1:0]                 rx_src,
    input  logic                              rx_pop,
    output logic                              misroute,
    output logic [7:0]                        misroute_cnt,
    output logic [$clog2(TX_DEPTH+1)-1:0]     tx_count,
    output logic [$clog2(RX_DEPTH+1)-1:0]     rx_count
);

    localparam int RX_W     = ADDR_W + DATA_W;
    localparam int DEST_LSB = dest_lsb(DATA_W, ADDR_W);
    localparam int SRC_LSB  = src_lsb(DATA_W);

    logic              tx_push;
    logic              tx_pop;
    logic [FLIT_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;

    logic              rx_push;
    logic [RX_W-1:0]   rx_wr_data;
    logic [RX_W-1:0]   rx_head;
    logic              rx_full;
    logic              rx_empty;

    logic              head_local;
    logic              net_accept;
    logic              net_for_us;
    logic              net_write;
    logic              loop_move;

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .wr_data ({proc_dest, current_node, proc_data}),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    sync_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (rx_wr_data),
        .pop     (rx_pop && rx_valid),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign proc_ready   = !tx_full && !rst;
    assign net_rx_ready = !rx_full && !rst;
    assign tx_push      = proc_valid && proc_ready;
    assign rx_valid     = !rx_empty;
    assign rx_data      = rx_valid ? rx_head[DATA_W-1:0] : '0;
    assign rx_src       = rx_valid ? rx_head[RX_W-1 -: ADDR_W] : '0;

    // Head dispatch and RX write-port arbitration: the network wins and a
    // blocked loopback head simply stays at the TX head until the next cycle.
    always_comb begin
        head_local   = 1'b0;
        net_tx_valid = 1'b0;
        net_tx_flit  = '0;
        net_accept   = 1'b0;
        net_for_us   = 1'b0;
        net_write    = 1'b0;
        loop_move    = 1'b0;
        rx_push      = 1'b0;
        rx_wr_data   = '0;
        tx_pop       = 1'b0;

        head_local   = !tx_empty && (tx_head[DEST_LSB +: ADDR_W] == current_node);
        net_tx_valid = !tx_empty && !head_local;
        if (net_tx_valid) net_tx_flit = tx_head;

        net_accept = net_rx_valid && net_rx_ready;
        net_for_us = (net_rx_flit[DEST_LSB +: ADDR_W] == current_node);
        net_write  = net_accept && net_for_us;
        loop_move  = head_local && !rx_full && !net_write;

        if (net_write) begin
            rx_push    = 1'b1;
            rx_wr_data = {net_rx_flit[SRC_LSB +: ADDR_W], net_rx_flit[DATA_W-1:0]};
        end else if (loop_move) begin
            rx_push    = 1'b1;
            rx_wr_data = {tx_head[SRC_LSB +: ADDR_W], tx_head[DATA_W-1:0]};
        end

        tx_pop = (net_tx_valid && net_tx_ready) || loop_move;
    end

    // Misrouted flits are dropped; flag them for one cycle and count them, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misroute     <= 1'b0;
            misroute_cnt <= '0;
        end else begin
            misroute <= net_accept && !net_for_us;
            if (net_accept && !net_for_us && (misroute_cnt != 8'hFF)) begin
                misroute_cnt <= misroute_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_proc_net_interface.sv
// tb_proc_net_interface: scenario tasks drive the interface; expected flits
// and received words are queued when stimulus is accepted and compared when
// the DUT hands them over.
module tb_proc_net_interface;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int FLIT_W = 36;
    localparam logic [ADDR_W-1:0] NODE = 2'd1;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] current_node;
    logic              proc_valid;
    logic              proc_ready;
    logic [ADDR_W-1:0] proc_dest;
    logic [DATA_W-1:0] proc_data;
    logic              net_tx_valid;
    logic              net_tx_ready;
    logic [FLIT_W-1:0] net_tx_flit;
    logic              net_rx_valid;
    logic              net_rx_ready;
    logic [FLIT_W-1:0] net_rx_flit;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [ADDR_W-1:0] rx_src;
    logic              rx_pop;
    logic              misroute;
    logic [7:0]        misroute_cnt;
    logic [2:0]        tx_count;
    logic [2:0]        rx_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_mis    = 0;

    logic [FLIT_W-1:0]        tx_q [$];
    logic [ADDR_W+DATA_W-1:0] rx_q [$];
    logic [FLIT_W-1:0]        mon_tx_exp;
    logic [ADDR_W+DATA_W-1:0] mon_rx_exp;

    proc_net_interface #(
        .DATA_W    (DATA_W),
        .NUM_NODES (4),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .current_node (current_node),
        .proc_valid   (proc_valid),
        .proc_ready   (proc_ready),
        .proc_dest    (proc_dest),
        .proc_data    (proc_data),
        .net_tx_valid (net_tx_valid),
        .net_tx_ready (net_tx_ready),
        .net_tx_flit  (net_tx_flit),
        .net_rx_valid (net_rx_valid),
        .net_rx_ready (net_rx_ready),
        .net_rx_flit  (net_rx_flit),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_src       (rx_src),
        .rx_pop       (rx_pop),
        .misroute     (misroute),
        .misroute_cnt (misroute_cnt),
        .tx_count     (tx_count),
        .rx_count     (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: at mid-cycle, any handshake about to complete is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && net_tx_valid && net_tx_ready) begin
            tests_run++;
            if (tx_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL tx_unexpected: got flit %h, expected none", net_tx_flit);
            end else begin
                mon_tx_exp = tx_q.pop_front();
                if (net_tx_flit !== mon_tx_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL tx_flit: got %h, expected %h", net_tx_flit, mon_tx_exp);
                end
            end
        end
        if (!rst && rx_valid && rx_pop) begin
            tests_run++;
            if (rx_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL rx_unexpected: got src %0d data %h, expected none", rx_src, rx_data);
            end else begin
                mon_rx_exp = rx_q.pop_front();
                if ({rx_src, rx_data} !== mon_rx_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL rx_word: got %h, expected %h", {rx_src, rx_data}, mon_rx_exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                             input bit record);
        bit accepted;
        accepted   = 1'b0;
        proc_dest  = dest;
        proc_data  = data;
        proc_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (proc_ready) accepted = 1'b1;
            tick();
        end
        proc_valid = 1'b0;
        tests_run++;
        if (!accepted) begin
            tests_failed++;
            $display("[TB] FAIL send_timeout: word %h not accepted, expected acceptance", data);
        end else if (record) begin
            if (dest != NODE) tx_q.push_back({dest, NODE, data});
            else              rx_q.push_back({NODE, data});
        end
    endtask

    task automatic inject_flit(input logic [ADDR_W-1:0] dest, input logic [ADDR_W-1:0] src,
                               input logic [DATA_W-1:0] data, input bit record);
        bit accepted;
        accepted     = 1'b0;
        net_rx_flit  = {dest, src, data};
        net_rx_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (net_rx_ready) accepted = 1'b1;
            tick();
        end
        net_rx_valid = 1'b0;
        tests_run++;
        if (!accepted) begin
            tests_failed++;
            $display("[TB] FAIL inject_timeout: flit %h not accepted, expected acceptance", data);
        end else if (record) begin
            if (dest == NODE) rx_q.push_back({src, data});
            else              model_mis = (model_mis == 255) ? 255 : model_mis + 1;
        end
    endtask

    task automatic pop_rx();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rx_valid) seen = 1'b1;
            else          tick();
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL rx_timeout: rx_valid 0, expected 1");
        end else begin
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
    endtask

    task automatic drain_tx();
        for (int i = 0; i < 50 && tx_q.size() > 0; i++) tick();
        tests_run++;
        if (tx_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL tx_drain: %0d flits outstanding, expected 0", tx_q.size());
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        current_node = NODE;
        proc_valid   = 1'b0;
        proc_dest    = '0;
        proc_data    = '0;
        net_tx_ready = 1'b1;
        net_rx_valid = 1'b0;
        net_rx_flit  = '0;
        rx_pop       = 1'b0;
        #2;
        tests_run++;
        if ({proc_ready, net_tx_valid, net_tx_flit, net_rx_ready, rx_valid, rx_data, rx_src,
             misroute, misroute_cnt, tx_count, rx_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: some output nonzero (proc_ready=%b net_rx_ready=%b tx_count=%0d), expected all 0",
                     proc_ready, net_rx_ready, tx_count);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({proc_ready, net_rx_ready} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL release_ready: got %b, expected 11", {proc_ready, net_rx_ready});
        end
        tests_run++;
        if ({net_tx_valid, net_tx_flit, rx_valid, rx_data, rx_src, misroute, misroute_cnt,
             tx_count, rx_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL release_outputs: some output nonzero, expected 0");
        end
        tick();
    endtask

    task automatic test_remote_send();
        net_tx_ready = 1'b1;
        send_word(2'd2, 32'hDEADBEEF, 1'b1);
        tests_run++;
        if (net_tx_valid !== 1'b1 || net_tx_flit !== {2'd2, 2'd1, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("[TB] FAIL remote_flit: got valid %b flit %h, expected valid 1 flit %h",
                     net_tx_valid, net_tx_flit, {2'd2, 2'd1, 32'hDEADBEEF});
        end
        tick();
        tests_run++;
        if (tx_count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL remote_pop: tx_count %0d, expected 0", tx_count);
        end
    endtask

    task automatic test_backpressure();
        net_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(2'(i == 1 ? 3 : 2), 32'hB000_0000 + i, 1'b1);
        tests_run++;
        if (proc_ready !== 1'b0 || tx_count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL bp_full: proc_ready %b tx_count %0d, expected 0 and 4", proc_ready, tx_count);
        end
        proc_valid = 1'b1;
        proc_dest  = 2'd2;
        proc_data  = 32'hB000_0004;
        tick();
        tick();
        proc_valid = 1'b0;
        tests_run++;
        if (tx_count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: tx_count %0d, expected 4", tx_count);
        end
        net_tx_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests_run++;
            if (tx_count !== 3'(4 - k) || proc_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL bp_release: tx_count %0d proc_ready %b, expected %0d and 1",
                         tx_count, proc_ready, 4 - k);
            end
        end
        send_word(2'd2, 32'hB000_0004, 1'b1);
        drain_tx();
    endtask

    task automatic test_back_to_back();
        net_tx_ready = 1'b1;
        send_word(2'd0, 32'h0000_1111, 1'b1);
        send_word(2'd3, 32'h0000_2222, 1'b1);
        send_word(2'd2, 32'h0000_3333, 1'b1);
        drain_tx();
    endtask

    task automatic test_loopback();
        send_word(NODE, 32'h12345678, 1'b1);
        tests_run++;
        if (net_tx_valid !== 1'b0 || rx_valid !== 1'b0 || tx_count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL loop_first: net_tx_valid %b rx_valid %b tx_count %0d, expected 0 0 1",
                     net_tx_valid, rx_valid, tx_count);
        end
        tick();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h12345678 || rx_src !== NODE || tx_count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL loop_arrive: rx_valid %b data %h src %0d tx_count %0d, expected 1 12345678 1 0",
                     rx_valid, rx_data, rx_src, tx_count);
        end
        pop_rx();
    endtask

    task automatic test_contention();
        send_word(NODE, 32'hAAAA_0001, 1'b0);
        inject_flit(NODE, 2'd3, 32'hBBBB_0002, 1'b1);
        rx_q.push_back({NODE, 32'hAAAA_0001});
        tests_run++;
        if (rx_count !== 3'd1 || tx_count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL cont_net_first: rx_count %0d tx_count %0d, expected 1 1", rx_count, tx_count);
        end
        tick();
        tests_run++;
        if (rx_count !== 3'd2 || tx_count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL cont_loop_next: rx_count %0d tx_count %0d, expected 2 0", rx_count, tx_count);
        end
        pop_rx();
        pop_rx();
    endtask

    task automatic test_misroute();
        inject_flit(2'd3, 2'd0, 32'hC0DE_0000, 1'b1);
        tests_run++;
        if (misroute !== 1'b1 || misroute_cnt !== 8'(model_mis) || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mis_first: misroute %b cnt %0d rx_valid %b, expected 1 %0d 0",
                     misroute, misroute_cnt, rx_valid, model_mis);
        end
        tick();
        tests_run++;
        if (misroute !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mis_pulse: misroute %b, expected 0", misroute);
        end
        for (int i = 1; i < 300; i++) inject_flit(2'(i % 2 == 0 ? 0 : 2), 2'd3, 32'(i), 1'b1);
        tick();
        tests_run++;
        if (misroute_cnt !== 8'(model_mis) || model_mis != 255) begin
            tests_failed++;
            $display("[TB] FAIL mis_saturate: cnt %0d, expected 255", misroute_cnt);
        end
        tests_run++;
        if (tx_q.size() != 0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: tx %0d rx %0d left, expected 0 0", tx_q.size(), rx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        net_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(2'd2, 32'hD000_0000 + i, 1'b0);
        for (int i = 0; i < 3; i++) inject_flit(NODE, 2'd0, 32'hE000_0000 + i, 1'b0);
        tests_run++;
        if (tx_count !== 3'd3 || rx_count !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL mid_fill: tx_count %0d rx_count %0d, expected 3 3", tx_count, rx_count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({proc_ready, net_tx_valid, net_tx_flit, net_rx_ready, rx_valid, rx_data, rx_src,
             misroute, misroute_cnt, tx_count, rx_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: cnt %0d tx %0d rx %0d rx_valid %b, expected all 0",
                     misroute_cnt, tx_count, rx_count, rx_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (tx_count !== 3'd0 || rx_count !== 3'd0 || proc_ready !== 1'b1 || net_rx_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_release: tx %0d rx %0d proc_ready %b net_rx_ready %b, expected 0 0 1 1",
                     tx_count, rx_count, proc_ready, net_rx_ready);
        end
        net_tx_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_remote_send();
        test_backpressure();
        test_back_to_back();
        test_loopback();
        test_contention();
        test_misroute();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
